// File: rtl/bram_fifo_pkg.sv
// Shared constants, pointer type and occupancy helper for the BRAM-backed FWFT FIFO controller.
package bram_fifo_pkg;

  localparam int FIFO_WIDTH  = 32;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);

  // Read/write pointer with one extra wrap bit so full and empty are distinguishable.
  typedef logic [FIFO_ADDR_W:0] ptr_t;

  // Room check for the output side: buffered words plus the in-flight read, minus the word leaving now.
  function automatic logic outbuf_has_room(input logic [1:0] out_cnt,
                                           input logic       rd_pend,
                                           input logic       pop);
    int occ;
    occ = int'(out_cnt) + int'(rd_pend) - int'(pop);
    return occ < 2;
  endfunction

endpackage

// File: rtl/bram_fifo_outbuf.sv
// 2-entry FWFT skid buffer behind the BRAM read port; a captured word is visible the cycle after cap_vld.
// No backpressure of its own: the caller only issues a read when a slot is guaranteed free.
module bram_fifo_outbuf
  import bram_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_vld,
  input  logic [WIDTH-1:0] cap_dat,
  input  logic             pop,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       out_cnt
);

  logic [WIDTH-1:0] tail_dat;

  assign m_valid = (out_cnt != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt  <= 2'd0;
      m_data   <= '0;
      tail_dat <= '0;
    end else begin
      unique case (out_cnt)
        2'd0: begin
          if (cap_vld) begin
            m_data  <= cap_dat;
            out_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (cap_vld && pop) begin
            m_data <= cap_dat;
          end else if (cap_vld) begin
            tail_dat <= cap_dat;
            out_cnt  <= 2'd2;
          end else if (pop) begin
            out_cnt <= 2'd0;
          end
        end
        default: begin
          // Full: the only legal capture here coincides with a pop, so the tail slides into the head.
          if (pop) begin
            m_data <= tail_dat;
            if (cap_vld) begin
              tail_dat <= cap_dat;
            end else begin
              out_cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FWFT FIFO controller around an external 1-cycle-read BRAM; a word pushed at edge t is presented after edge t+2.
// s_ready drops at DEPTH words; m_ready low stalls reads. BRAM_FIFO_ALMOST_EN adds registered almost_full/almost_empty.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH,
  parameter int DEPTH    = FIFO_DEPTH,
`ifdef BRAM_FIFO_ALMOST_EN
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
`endif
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
`ifdef BRAM_FIFO_ALMOST_EN
  output logic              almost_full,
  output logic              almost_empty,
`endif
  output logic [ADDR_W:0]   count,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wr_add,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_add,
  input  logic [WIDTH-1:0]  mem_rd_data
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] ONE      = CW'(1);
  localparam logic [ADDR_W:0] FULL_LVL = CW'(DEPTH);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            rd_pend;
  logic [1:0]      out_cnt;
  logic            push;
  logic            pop;
  logic            rd_issue;

  assign s_ready  = !rst && (count < FULL_LVL);
  assign push     = s_valid && s_ready;
  assign pop      = m_valid && m_ready;
  assign rd_issue = !rst && (wr_ptr != rd_ptr) && outbuf_has_room(out_cnt, rd_pend, pop);

  assign mem_we      = push;
  assign mem_wr_add  = wr_ptr[ADDR_W-1:0];
  assign mem_wr_data = s_data;
  assign mem_rd_en   = rd_issue;
  assign mem_rd_add  = rd_ptr[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
      count   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + ONE;
      end
      rd_pend <= rd_issue;
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
    end
  end

  // rd_pend clears on reset, so a read launched just before reset is never captured.
  bram_fifo_outbuf #(
    .WIDTH (WIDTH)
  ) u_outbuf (
    .clk     (clk),
    .rst     (rst),
    .cap_vld (rd_pend),
    .cap_dat (mem_rd_data),
    .pop     (pop),
    .m_valid (m_valid),
    .m_data  (m_data),
    .out_cnt (out_cnt)
  );

`ifdef BRAM_FIFO_ALMOST_EN
  localparam logic [ADDR_W:0] AF_C = CW'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C = CW'(AE_LEVEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count >= AF_C);
      almost_empty <= (count <= AE_C);
    end
  end
`endif

  // Occupancy bookkeeping must agree with the pointers, and a write never lands on the address being read.
  assert property (@(posedge clk) disable iff (rst) count <= FULL_LVL);
  assert property (@(posedge clk) disable iff (rst)
                   count == CW'(wr_ptr - rd_ptr) + CW'(rd_pend) + CW'(out_cnt));
  assert property (@(posedge clk) disable iff (rst)
                   (rd_issue && push) |-> (mem_rd_add != mem_wr_add));

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a behavioural BRAM and a queue-based output scoreboard.
module tb_bram_fifo_ctrl;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [WIDTH-1:0]  s_data;
  logic              m_valid;
  logic              m_ready;
  logic [WIDTH-1:0]  m_data;
  logic [ADDR_W:0]   count;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wr_add;
  logic [WIDTH-1:0]  mem_wr_data;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_add;
  logic [WIDTH-1:0]  mem_rd_data;
`ifdef BRAM_FIFO_ALMOST_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  int n_chk = 0;
  int n_err = 0;
  int pops = 0;
  int max_cnt = 0;
  int model_cnt = 0;
  int cyc = 0;
  int t0;
  int p0;
  bit t4_done;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] bram [DEPTH];

  bram_fifo_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
`ifdef BRAM_FIFO_ALMOST_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .count        (count),
    .mem_we       (mem_we),
    .mem_wr_add   (mem_wr_add),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_add   (mem_rd_add),
    .mem_rd_data  (mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) bram[mem_wr_add] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= bram[mem_rd_add];
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: handshakes are sampled mid-cycle, so they describe what the next edge will do.
  always @(negedge clk) begin : monitor
    logic [WIDTH-1:0] e;
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      chk("count_track", 32'(count), 32'(model_cnt));
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL pop_when_empty: got %0h, expected no word (t=%0t)", m_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", m_data, e);
        end
        model_cnt--;
        pops++;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        model_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    #1;
    while (!s_ready && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("send_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    while (count != '0 && n < 100) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hFFFF_FFFF;
    m_ready = 1'b1;
    #2;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
`ifdef BRAM_FIFO_ALMOST_EN
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
`endif
    tick();
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst     = 1'b0;
    tick();

    // Single word through an empty FIFO: write, read issue, then head presented after the capture edge.
    s_valid = 1'b1;
    s_data  = 32'hA5A5_0001;
    #1;
    chk("t1_mem_we", 32'(mem_we), 32'd1);
    chk("t1_wr_add", 32'(mem_wr_add), 32'd0);
    chk("t1_wr_data", mem_wr_data, 32'hA5A5_0001);
    tick();
    s_valid = 1'b0;
    #1;
    chk("t1_rd_en", 32'(mem_rd_en), 32'd1);
    chk("t1_rd_add", 32'(mem_rd_add), 32'd0);
    chk("t1_count", 32'(count), 32'd1);
    tick();
    chk("t1_rd_idle", 32'(mem_rd_en), 32'd0);
    tick();
    chk("t1_m_valid", 32'(m_valid), 32'd1);
    chk("t1_m_data", m_data, 32'hA5A5_0001);
    chk("t1_count_hold", 32'(count), 32'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    chk("t1_empty", 32'(m_valid), 32'd0);
    tick();

    // Fill to capacity, then a blocked write must not reach the BRAM.
    for (int i = 0; i < 8; i++) send(32'(i));
    #1;
    chk("t2_s_ready", 32'(s_ready), 32'd0);
    chk("t2_count", 32'(count), 32'd8);
    s_valid = 1'b1;
    s_data  = 32'h0000_DEAD;
    #1;
    chk("t2_mem_we", 32'(mem_we), 32'd0);
    tick();
    chk("t2_hold_count", 32'(count), 32'd8);
    s_valid = 1'b0;
    drain();

    // Continuous stream: every send takes one cycle; word k is popped at edge k+3, leaving 3 held after 20 pushes.
    m_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 20; i++) send(32'(i));
    chk("t3_cycles", 32'(cyc - t0), 32'd20);
    #1;
    chk("t3_count", 32'(count), 32'd3);
    drain();

    // Full FIFO with bursty consumer while more words arrive.
    for (int i = 0; i < 8; i++) send(32'(90 + i));
    #1;
    chk("t4_full", 32'(count), 32'd8);
    p0 = pops;
    t4_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(32'(100 + i));
        t4_done = 1'b1;
      end
      begin
        int k = 0;
        while (!t4_done && k < 2000) begin
          m_ready = (k % 3 == 0);
          tick();
          k++;
        end
      end
    join
    drain();
    chk("t4_pops", 32'(pops - p0), 32'd24);
    chk("count_max", 32'(max_cnt), 32'd8);

    // Reset with a BRAM read in flight: nothing stale may surface afterwards.
    for (int i = 0; i < 3; i++) send(32'h300 + 32'(i));
    repeat (3) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("t5_m_valid", 32'(m_valid), 32'd0);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_s_ready", 32'(s_ready), 32'd0);
    chk("t5_rd_en", 32'(mem_rd_en), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t5_no_stale", 32'(m_valid), 32'd0);
    chk("t5_count_idle", 32'(count), 32'd0);
    send(32'h55);
    n = 0;
    while (!m_valid && n < 10) begin
      tick();
      n++;
    end
    chk("t5_valid", 32'(m_valid), 32'd1);
    chk("t5_head", m_data, 32'h55);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    chk("t5_drained", 32'(count), 32'd0);
    tick();

`ifdef BRAM_FIFO_ALMOST_EN
    // Flags are registered copies of the count thresholds, one cycle behind count.
    chk("t6_ae_empty", 32'(almost_empty), 32'd1);
    chk("t6_af_empty", 32'(almost_full), 32'd0);
    for (int i = 0; i < 6; i++) send(32'h600 + 32'(i));
    chk("t6_af_lag", 32'(almost_full), 32'd0);
    tick();
    chk("t6_af_set", 32'(almost_full), 32'd1);
    chk("t6_ae_clear", 32'(almost_empty), 32'd0);
    m_ready = 1'b1;
    n = 0;
    while (count > 4'd2 && n < 20) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    chk("t6_count2", 32'(count), 32'd2);
    chk("t6_ae_lag", 32'(almost_empty), 32'd0);
    tick();
    chk("t6_ae_set", 32'(almost_empty), 32'd1);
    chk("t6_af_clear", 32'(almost_full), 32'd0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
